dds_signal_meter: RTL and testbench
===================================

Name: dds_signal_meter

Overview:
- Measurement (receive) end of the waveform generator output path: consumes the 16-bit unsigned offset-binary sample stream the generator drives out.
- Per waveform period, reports period length in clock cycles, high time, and sample max/min.
- Intended for closed-loop self-test of frequency tuning, phase/PWM duty and amplitude, and as an optional data source for the 7-segment display.

Parameters:
- MID, 32768, midpoint threshold for the high/low decision and for high_time.
- HYST, 1024, hysteresis half-width; legal range is MID ≥ HYST and MID+HYST ≤ 65535.
- CNT_W, 32, width of the period and high_time counters.
- MAX_PERIOD, 2^CNT_W-1, cycle count at which a measurement times out.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  1 = measure; 0 = abort, return to ARM_LOW, clear counters, hold outputs
- sample_in  in  16  unsigned sample, one per clk
- period  out  CNT_W  cycles between successive rising crossings
- high_time  out  CNT_W  cycles within that period with sample ≥ MID
- sample_max  out  16  largest sample in that period
- sample_min  out  16  smallest sample in that period
- meas_valid  out  1  one-cycle pulse when new results are latched
- locked  out  1  1 after first published measurement; 0 after timeout, reset or enable=0
- timeout  out  1  level; set on timeout, cleared on next meas_valid or reset

Behaviour:
- Reset values: all outputs 0, state ARM_LOW, counters 0.
- Reset wins over every other event on the same edge, including mid-measurement; any partial measurement is discarded.
- Threshold decisions:
  - low event: sample_in < MID-HYST
  - rise event: sample_in ≥ MID+HYST
  - samples inside the band never change state
- States:
  - ARM_LOW: on low event → ARM_HIGH.
  - ARM_HIGH: on rise event → MEAS_LOW; start window (cnt=1, hi=1, max=min=sample).
  - MEAS_LOW: accumulate; on low event → MEAS_HIGH.
  - MEAS_HIGH: accumulate; on rise event (crossing), publish, restart window with the crossing sample, → MEAS_LOW.
- Accumulate, per enabled cycle in MEAS states:
  - cnt += 1
  - hi += (sample ≥ MID)
  - max/min updated
- Window rule: the crossing sample is the first sample of the new window and is excluded from the old one. So period = cycle distance between crossing samples, and high_time ≤ period.
- Publish: on the crossing edge, period←cnt, high_time←hi, sample_max←max, sample_min←min. On the same edge, meas_valid=1, locked=1, timeout=0. Outputs are therefore visible the cycle after the crossing sample.
- meas_valid is exactly one cycle; back-to-back pulses are legal only if period ≥ 2, which the hysteresis guarantees.
- Timeout: in MEAS_LOW/MEAS_HIGH, if cnt == MAX_PERIOD and this cycle is not a crossing, then timeout=1, locked=0, → ARM_LOW, and outputs hold their last values.
- Simultaneous crossing and cnt == MAX_PERIOD: the crossing wins and period=MAX_PERIOD is published. Counters never wrap.
- enable=0: state → ARM_LOW, counters cleared, locked=0, meas_valid=0, timeout and result outputs hold. Re-enable requires a fresh low→rise sequence before timing starts.
- No measurement is published before two rising crossings after arming. The first crossing only opens the window.

Test Plan:
- Square stimulus, 40 cycles 0xF000 then 60 cycles 0x1000, repeated → first meas_valid one cycle after the 2nd rising sample with period=100, high_time=40, sample_max=0xF000, sample_min=0x1000, locked=1. Every later pulse repeats at 100-cycle spacing.
- Noise near threshold, sample toggling 0x8000/0x83FF (inside band) between crossings of the 100-cycle square → no extra meas_valid, period stays 100.
- Timeout with MAX_PERIOD=500: lock, then hold sample_in=0x1000 → timeout=1, locked=0 exactly when cnt reaches 500, outputs unchanged. Restore square → after two crossings, timeout=0 and period=100.
- Crossing coincident with cnt==MAX_PERIOD (MAX_PERIOD=100, 100-cycle square) → meas_valid with period=100, timeout stays 0.
- Reset mid-window (assert for 1 cycle 50 cycles after a crossing) → all outputs 0 next cycle. The first meas_valid needs a full low→rise→rise sequence.
- enable dropped for 10 cycles mid-window → locked=0, no meas_valid, prior period retained. After re-enable, the next publish needs two crossings and shows the correct 100.

Source files
------------

// File: rtl/dds_signal_meter_if.sv
// Sample stream in, per-period measurement results out.
// Meter side uses the slave modport.
interface dds_signal_meter_if #(
  parameter int CNT_W = 32
);
  logic             enable;
  logic [15:0]      sample_in;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic [15:0]      sample_max;
  logic [15:0]      sample_min;
  logic             meas_valid;
  logic             locked;
  logic             timeout;

  modport master (
    output enable,
    output sample_in,
    input  period,
    input  high_time,
    input  sample_max,
    input  sample_min,
    input  meas_valid,
    input  locked,
    input  timeout
  );

  modport slave (
    input  enable,
    input  sample_in,
    output period,
    output high_time,
    output sample_max,
    output sample_min,
    output meas_valid,
    output locked,
    output timeout
  );
endinterface

// File: rtl/dds_signal_meter.sv
// Period / high-time / peak meter for the DDS output stream.
// Hysteretic rising-crossing detector opens and closes each window.
module dds_signal_meter #(
  parameter int               MID        = 32768,
  parameter int               HYST       = 1024,
  parameter int               CNT_W      = 32,
  parameter logic [CNT_W-1:0] MAX_PERIOD = '1
) (
  input logic               clk,
  input logic               reset,
  dds_signal_meter_if.slave bus
);

  localparam logic [15:0] LO_TH = 16'(MID - HYST);
  localparam logic [15:0] HI_TH = 16'(MID + HYST);
  localparam logic [15:0] MID_V = 16'(MID);

  typedef enum logic [1:0] {
    ARM_LOW,
    ARM_HIGH,
    MEAS_LOW,
    MEAS_HIGH
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] hi, hi_n;
  logic [15:0]      mx, mx_n;
  logic [15:0]      mn, mn_n;
  logic [CNT_W-1:0] per_q, per_n;
  logic [CNT_W-1:0] ht_q, ht_n;
  logic [15:0]      max_q, max_n;
  logic [15:0]      min_q, min_n;
  logic             vld_q, vld_n;
  logic             lck_q, lck_n;
  logic             tmo_q, tmo_n;

  logic [15:0]      s;
  logic             low_ev;
  logic             rise_ev;
  logic             is_high;
  logic             at_max;
  logic [CNT_W-1:0] cnt_a;
  logic [CNT_W-1:0] hi_a;
  logic [15:0]      mx_a;
  logic [15:0]      mn_a;

  assign s       = bus.sample_in;
  assign low_ev  = s < LO_TH;
  assign rise_ev = s >= HI_TH;
  assign is_high = s >= MID_V;
  assign at_max  = cnt == MAX_PERIOD;

  // Running window accumulation including the current sample.
  always_comb begin
    cnt_a = cnt + CNT_W'(1);
    hi_a  = hi + CNT_W'(is_high);
    mx_a  = (s > mx) ? s : mx;
    mn_a  = (s < mn) ? s : mn;
  end

  // Next-state, window and result update.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    hi_n    = hi;
    mx_n    = mx;
    mn_n    = mn;
    per_n   = per_q;
    ht_n    = ht_q;
    max_n   = max_q;
    min_n   = min_q;
    vld_n   = 1'b0;
    lck_n   = lck_q;
    tmo_n   = tmo_q;
    if (!bus.enable) begin
      state_n = ARM_LOW;
      cnt_n   = '0;
      hi_n    = '0;
      mx_n    = '0;
      mn_n    = '0;
      lck_n   = 1'b0;
    end else begin
      unique case (state)
        ARM_LOW: begin
          if (low_ev) state_n = ARM_HIGH;
        end
        ARM_HIGH: begin
          if (rise_ev) begin
            state_n = MEAS_LOW;
            cnt_n   = CNT_W'(1);
            hi_n    = CNT_W'(is_high);
            mx_n    = s;
            mn_n    = s;
          end
        end
        MEAS_LOW: begin
          if (at_max) begin
            state_n = ARM_LOW;
            cnt_n   = '0;
            hi_n    = '0;
            tmo_n   = 1'b1;
            lck_n   = 1'b0;
          end else begin
            cnt_n = cnt_a;
            hi_n  = hi_a;
            mx_n  = mx_a;
            mn_n  = mn_a;
            if (low_ev) state_n = MEAS_HIGH;
          end
        end
        MEAS_HIGH: begin
          if (rise_ev) begin
            // crossing sample closes the old window, opens the new
            per_n   = cnt;
            ht_n    = hi;
            max_n   = mx;
            min_n   = mn;
            vld_n   = 1'b1;
            lck_n   = 1'b1;
            tmo_n   = 1'b0;
            state_n = MEAS_LOW;
            cnt_n   = CNT_W'(1);
            hi_n    = CNT_W'(is_high);
            mx_n    = s;
            mn_n    = s;
          end else if (at_max) begin
            state_n = ARM_LOW;
            cnt_n   = '0;
            hi_n    = '0;
            tmo_n   = 1'b1;
            lck_n   = 1'b0;
          end else begin
            cnt_n = cnt_a;
            hi_n  = hi_a;
            mx_n  = mx_a;
            mn_n  = mn_a;
          end
        end
        default: state_n = ARM_LOW;
      endcase
    end
  end

  // State, window and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ARM_LOW;
      cnt   <= '0;
      hi    <= '0;
      mx    <= '0;
      mn    <= '0;
      per_q <= '0;
      ht_q  <= '0;
      max_q <= '0;
      min_q <= '0;
      vld_q <= 1'b0;
      lck_q <= 1'b0;
      tmo_q <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      hi    <= hi_n;
      mx    <= mx_n;
      mn    <= mn_n;
      per_q <= per_n;
      ht_q  <= ht_n;
      max_q <= max_n;
      min_q <= min_n;
      vld_q <= vld_n;
      lck_q <= lck_n;
      tmo_q <= tmo_n;
    end
  end

  assign bus.period     = per_q;
  assign bus.high_time  = ht_q;
  assign bus.sample_max = max_q;
  assign bus.sample_min = min_q;
  assign bus.meas_valid = vld_q;
  assign bus.locked     = lck_q;
  assign bus.timeout    = tmo_q;

endmodule

// File: tb/tb_dds_signal_meter.sv
// Directed bench for dds_signal_meter.
// u0 default, u1 MAX_PERIOD=500, u2 MAX_PERIOD=100.
module tb_dds_signal_meter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic [15:0] sample = 16'h1000;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int pulses0 = 0;
  int pulses1 = 0;
  int pulses2 = 0;
  int first0 = -1;
  int last0 = -1;
  int prev0 = -1;
  int last_cross = 0;

  dds_signal_meter_if #(.CNT_W(32)) b0 ();
  dds_signal_meter_if #(.CNT_W(32)) b1 ();
  dds_signal_meter_if #(.CNT_W(32)) b2 ();

  assign b0.enable    = enable;
  assign b0.sample_in = sample;
  assign b1.enable    = enable;
  assign b1.sample_in = sample;
  assign b2.enable    = enable;
  assign b2.sample_in = sample;

  dds_signal_meter u0 (
    .clk(clk), .reset(reset), .bus(b0)
  );
  dds_signal_meter #(.MAX_PERIOD(32'd500)) u1 (
    .clk(clk), .reset(reset), .bus(b1)
  );
  dds_signal_meter #(.MAX_PERIOD(32'd100)) u2 (
    .clk(clk), .reset(reset), .bus(b2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (b0.meas_valid) begin
      if (pulses0 == 0) first0 = cyc;
      prev0 = last0;
      last0 = cyc;
      pulses0++;
    end
    if (b1.meas_valid) pulses1++;
    if (b2.meas_valid) pulses2++;
  end

  task automatic drv(input logic [15:0] v);
    @(negedge clk);
    sample = v;
  endtask

  task automatic run_square(input int n);
    for (int p = 0; p < n; p++) begin
      for (int i = 0; i < 40; i++) begin
        drv(16'hF000);
        if (i == 0) last_cross = cyc + 1;
      end
      for (int i = 0; i < 60; i++) drv(16'h1000);
    end
    #1;
  endtask

  task automatic check_zero(input string tag);
    n_chk++;
    if (b0.period !== 32'd0) begin
      n_fail++;
      $display("FAIL %s period got %0d want 0", tag, b0.period);
    end
    n_chk++;
    if (b0.high_time !== 32'd0) begin
      n_fail++;
      $display("FAIL %s high_time got %0d want 0",
               tag, b0.high_time);
    end
    n_chk++;
    if (b0.sample_max !== 16'h0 || b0.sample_min !== 16'h0) begin
      n_fail++;
      $display("FAIL %s max/min got %h/%h want 0/0",
               tag, b0.sample_max, b0.sample_min);
    end
    n_chk++;
    if ({b0.meas_valid, b0.locked, b0.timeout} !== 3'b000) begin
      n_fail++;
      $display("FAIL %s vld/lck/tmo got %b%b%b want 000", tag,
               b0.meas_valid, b0.locked, b0.timeout);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) drv(16'h1000);
    #1;
    check_zero("reset");
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_square;
    int c2;
    repeat (10) drv(16'h1000);
    run_square(1);
    n_chk++;
    if (pulses0 !== 0) begin
      n_fail++;
      $display("FAIL first_cross_no_pulse got %0d want 0", pulses0);
    end
    run_square(1);
    c2 = last_cross;
    run_square(1);
    n_chk++;
    if (first0 !== c2) begin
      n_fail++;
      $display("FAIL first_pulse_cycle got %0d want %0d", first0, c2);
    end
    n_chk++;
    if (pulses0 !== 2 || last0 - prev0 !== 100) begin
      n_fail++;
      $display("FAIL pulse_spacing got n=%0d d=%0d want n=2 d=100",
               pulses0, last0 - prev0);
    end
    n_chk++;
    if (b0.period !== 32'd100 || b0.high_time !== 32'd40) begin
      n_fail++;
      $display("FAIL square_period got %0d/%0d want 100/40",
               b0.period, b0.high_time);
    end
    n_chk++;
    if (b0.sample_max !== 16'hF000 || b0.sample_min !== 16'h1000) begin
      n_fail++;
      $display("FAIL square_peaks got %h/%h want f000/1000",
               b0.sample_max, b0.sample_min);
    end
    n_chk++;
    if (b0.locked !== 1'b1 || b0.timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL square_lock got %b/%b want 1/0",
               b0.locked, b0.timeout);
    end
  endtask

  task automatic test_coincide;
    n_chk++;
    if (pulses2 !== 2 || b2.period !== 32'd100) begin
      n_fail++;
      $display("FAIL coincide got n=%0d p=%0d want n=2 p=100",
               pulses2, b2.period);
    end
    n_chk++;
    if (b2.timeout !== 1'b0 || b2.locked !== 1'b1) begin
      n_fail++;
      $display("FAIL coincide_tmo got %b/%b want 0/1",
               b2.timeout, b2.locked);
    end
  endtask

  task automatic test_noise;
    int p;
    p = pulses0;
    for (int i = 0; i < 40; i++) begin
      drv(16'hF000);
    end
    for (int i = 0; i < 20; i++) begin
      drv((i % 2 == 0) ? 16'h7C00 : 16'h83FF);
    end
    for (int i = 0; i < 40; i++) drv(16'h1000);
    run_square(1);
    n_chk++;
    if (pulses0 !== p + 2) begin
      n_fail++;
      $display("FAIL noise_pulses got %0d want %0d", pulses0, p + 2);
    end
    n_chk++;
    if (b0.period !== 32'd100 || b0.high_time !== 32'd50) begin
      n_fail++;
      $display("FAIL noise_period got %0d/%0d want 100/50",
               b0.period, b0.high_time);
    end
    n_chk++;
    if (b0.sample_max !== 16'hF000 || b0.sample_min !== 16'h1000) begin
      n_fail++;
      $display("FAIL noise_peaks got %h/%h want f000/1000",
               b0.sample_max, b0.sample_min);
    end
  endtask

  task automatic test_timeout;
    run_square(1);
    for (int i = 0; i < 401; i++) drv(16'h1000);
    #1;
    n_chk++;
    if (b1.timeout !== 1'b0 || b1.locked !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_timeout got %b/%b want 0/1",
               b1.timeout, b1.locked);
    end
    drv(16'h1000);
    #1;
    n_chk++;
    if (b1.timeout !== 1'b1 || b1.locked !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout got %b/%b want 1/0",
               b1.timeout, b1.locked);
    end
    n_chk++;
    if (b1.period !== 32'd100 || b1.high_time !== 32'd40) begin
      n_fail++;
      $display("FAIL timeout_hold got %0d/%0d want 100/40",
               b1.period, b1.high_time);
    end
    n_chk++;
    if (b0.timeout !== 1'b0 || b0.locked !== 1'b1) begin
      n_fail++;
      $display("FAIL default_no_timeout got %b/%b want 0/1",
               b0.timeout, b0.locked);
    end
    repeat (5) drv(16'h1000);
    run_square(1);
    n_chk++;
    if (b1.timeout !== 1'b1 || b1.locked !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_one_cross got %b/%b want 1/0",
               b1.timeout, b1.locked);
    end
    run_square(1);
    n_chk++;
    if (b1.timeout !== 1'b0 || b1.locked !== 1'b1 ||
        b1.period !== 32'd100) begin
      n_fail++;
      $display("FAIL timeout_recover got %b/%b/%0d want 0/1/100",
               b1.timeout, b1.locked, b1.period);
    end
  endtask

  task automatic test_reset_mid;
    int p;
    run_square(1);
    for (int i = 0; i < 40; i++) drv(16'hF000);
    for (int i = 0; i < 10; i++) drv(16'h1000);
    @(negedge clk);
    reset = 1'b1;
    sample = 16'h1000;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_zero("reset_mid");
    p = pulses0;
    repeat (10) drv(16'h1000);
    run_square(1);
    n_chk++;
    if (pulses0 !== p) begin
      n_fail++;
      $display("FAIL reset_rearm got %0d want %0d", pulses0, p);
    end
    run_square(1);
    n_chk++;
    if (pulses0 !== p + 1 || b0.period !== 32'd100) begin
      n_fail++;
      $display("FAIL reset_relock got n=%0d p=%0d want n=%0d p=100",
               pulses0, b0.period, p + 1);
    end
  endtask

  task automatic test_enable;
    int p;
    for (int i = 0; i < 40; i++) drv(16'hF000);
    for (int i = 0; i < 10; i++) drv(16'h1000);
    #1;
    p = pulses0;
    @(negedge clk);
    enable = 1'b0;
    sample = 16'h1000;
    for (int i = 1; i < 10; i++) begin
      drv((i < 5) ? 16'h1000 : 16'hF000);
    end
    #1;
    n_chk++;
    if (b0.locked !== 1'b0 || pulses0 !== p) begin
      n_fail++;
      $display("FAIL disable got lck=%b n=%0d want 0/%0d",
               b0.locked, pulses0, p);
    end
    n_chk++;
    if (b0.period !== 32'd100) begin
      n_fail++;
      $display("FAIL disable_hold got %0d want 100", b0.period);
    end
    @(negedge clk);
    enable = 1'b1;
    sample = 16'h1000;
    repeat (9) drv(16'h1000);
    run_square(1);
    n_chk++;
    if (pulses0 !== p || b0.locked !== 1'b0) begin
      n_fail++;
      $display("FAIL reenable_first got n=%0d lck=%b want %0d/0",
               pulses0, b0.locked, p);
    end
    run_square(1);
    n_chk++;
    if (pulses0 !== p + 1 || b0.period !== 32'd100 ||
        b0.locked !== 1'b1) begin
      n_fail++;
      $display("FAIL reenable got n=%0d p=%0d lck=%b want %0d/100/1",
               pulses0, b0.period, b0.locked, p + 1);
    end
  endtask

  initial begin
    test_reset;
    test_square;
    test_coincide;
    test_noise;
    test_timeout;
    test_reset_mid;
    test_enable;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
